// File: rtl/fsm_ctrl_n_pkg.sv
// fsm_ctrl_pkg: state indices, one-hot state constants, defaults.
// Shared by the fsm_ctrl_n top, its interface and threshold slice.
package fsm_ctrl_pkg;

  localparam int S_RESET    = 0;
  localparam int S_INIT     = 1;
  localparam int S_IDLE     = 2;
  localparam int S_ACTIVE   = 3;
  localparam int S_PAUSE    = 4;
  localparam int S_CONTINUE = 5;
  localparam int S_ERROR    = 6;
  localparam int NUM_STATES = 7;

  localparam int TH_HIGH_DEF_C = 6;
  localparam int TH_LOW_DEF_C  = 2;

  typedef logic [NUM_STATES-1:0] state_oh_t;

  localparam logic [6:0] ST_RESET    = 7'b0000001;
  localparam logic [6:0] ST_INIT     = 7'b0000010;
  localparam logic [6:0] ST_IDLE     = 7'b0000100;
  localparam logic [6:0] ST_ACTIVE   = 7'b0001000;
  localparam logic [6:0] ST_PAUSE    = 7'b0010000;
  localparam logic [6:0] ST_CONTINUE = 7'b0100000;
  localparam logic [6:0] ST_ERROR    = 7'b1000000;

endpackage

// File: rtl/fsm_ctrl_n_if.sv
// fsm_ctrl_n_if: FIFO status, config load and control outputs.
// master = FIFO bank / host side, slave = controller.
interface fsm_ctrl_n_if #(
  parameter int NUM_FIFOS = 4,
  parameter int CNT_W     = 4,
  parameter int ARB_W     = 3
);
  logic                       init;
  logic [NUM_FIFOS-1:0]       fifo_empty;
  logic [NUM_FIFOS-1:0]       fifo_full;
  logic [NUM_FIFOS-1:0]       fifo_wr;
  logic [NUM_FIFOS-1:0]       fifo_rd;
  logic [NUM_FIFOS*CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0]           th_high_in;
  logic [CNT_W-1:0]           th_low_in;
  logic [NUM_FIFOS*ARB_W-1:0] arb_w_in;
  logic [CNT_W-1:0]           th_high;
  logic [CNT_W-1:0]           th_low;
  logic [NUM_FIFOS*ARB_W-1:0] arb_w;
  logic [6:0]                 state_o;
  logic                       idle;
  logic [NUM_FIFOS-1:0]       pause_o;
  logic [NUM_FIFOS-1:0]       continue_o;
  logic [NUM_FIFOS-1:0]       error_full;
  logic                       cfg_invalid;

  modport master (
    output init, fifo_empty, fifo_full,
    output fifo_wr, fifo_rd, fifo_count,
    output th_high_in, th_low_in, arb_w_in,
    input  th_high, th_low, arb_w,
    input  state_o, idle, pause_o,
    input  continue_o, error_full,
    input  cfg_invalid
  );

  modport slave (
    input  init, fifo_empty, fifo_full,
    input  fifo_wr, fifo_rd, fifo_count,
    input  th_high_in, th_low_in, arb_w_in,
    output th_high, th_low, arb_w,
    output state_o, idle, pause_o,
    output continue_o, error_full,
    output cfg_invalid
  );
endinterface

// File: rtl/fsm_ctrl_n_thr.sv
// fsm_ctrl_thr: one channel's hysteresis compare and
// overflow detect; pure combinational.
module fsm_ctrl_thr #(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] th_high_i,
  input  logic [CNT_W-1:0] th_low_i,
  input  logic             paused_i,
  input  logic             full_i,
  input  logic             wr_i,
  input  logic             rd_i,
  output logic             pause_ev_o,
  output logic             cont_ev_o,
  output logic             err_ev_o
);

  assign pause_ev_o = ~paused_i & (count_i >= th_high_i);
  assign cont_ev_o  =  paused_i & (count_i <= th_low_i);
  assign err_ev_o   = full_i & wr_i & ~rd_i;

endmodule

// File: rtl/fsm_ctrl_n.sv
// fsm_ctrl_n: config owner, pause/continue hysteresis FSM.
// `define FSM_ERR_RECOVER_EN lets init leave ERROR.
module fsm_ctrl_n
  import fsm_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS   = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = $clog2(FIFO_DEPTH+1),
  parameter int ARB_W       = 3,
  parameter int TH_HIGH_DEF = TH_HIGH_DEF_C,
  parameter int TH_LOW_DEF  = TH_LOW_DEF_C
) (
  input logic         clk,
  input logic         rst,
  fsm_ctrl_n_if.slave bus
);

  localparam int N  = NUM_FIFOS;
  localparam int AW = NUM_FIFOS*ARB_W;

  state_oh_t         state_q, state_d;
  logic [CNT_W-1:0]  th_high_q, th_high_d;
  logic [CNT_W-1:0]  th_low_q, th_low_d;
  logic [AW-1:0]     arb_w_q, arb_w_d;
  logic [N-1:0]      paused_q, paused_d;
  logic [N-1:0]      pmask_q, pmask_d;
  logic [N-1:0]      cmask_q, cmask_d;
  logic [N-1:0]      err_full_q, err_full_d;
  logic              cfg_inv_q, cfg_inv_d;

  logic [N-1:0]      pause_ev;
  logic [N-1:0]      cont_ev;
  logic [N-1:0]      err_ev;
  logic              err_any;
  logic              all_empty;
  logic              recover;

  for (genvar i = 0; i < N; i++) begin : g_thr
    fsm_ctrl_thr #(.CNT_W(CNT_W)) u_thr (
      .count_i    (bus.fifo_count[i*CNT_W +: CNT_W]),
      .th_high_i  (th_high_q),
      .th_low_i   (th_low_q),
      .paused_i   (paused_q[i]),
      .full_i     (bus.fifo_full[i]),
      .wr_i       (bus.fifo_wr[i]),
      .rd_i       (bus.fifo_rd[i]),
      .pause_ev_o (pause_ev[i]),
      .cont_ev_o  (cont_ev[i]),
      .err_ev_o   (err_ev[i])
    );
  end

  assign err_any   = |err_ev;
  assign all_empty = &bus.fifo_empty;

`ifdef FSM_ERR_RECOVER_EN
  assign recover = state_q[S_ERROR] & bus.init;
`else
  assign recover = 1'b0;
`endif

  // next-state: error, then init, then per-state move
  always_comb begin
    state_d = ST_RESET;
    if (state_q[S_ERROR]) begin
      state_d = recover ? ST_INIT : ST_ERROR;
    end else if (err_any) begin
      state_d = ST_ERROR;
    end else if (bus.init) begin
      state_d = ST_INIT;
    end else begin
      unique case (1'b1)
        state_q[S_RESET]:    state_d = ST_INIT;
        state_q[S_INIT]:     state_d = ST_IDLE;
        state_q[S_IDLE]:
          state_d = all_empty ? ST_IDLE : ST_ACTIVE;
        state_q[S_ACTIVE]: begin
          if (|pause_ev)     state_d = ST_PAUSE;
          else if (|cont_ev) state_d = ST_CONTINUE;
          else if (all_empty) state_d = ST_IDLE;
          else               state_d = ST_ACTIVE;
        end
        state_q[S_PAUSE]:    state_d = ST_ACTIVE;
        state_q[S_CONTINUE]: state_d = ST_ACTIVE;
        default:             state_d = ST_RESET;
      endcase
    end
  end

  // config load; an inverted threshold pair is dropped
  always_comb begin
    th_high_d = th_high_q;
    th_low_d  = th_low_q;
    arb_w_d   = arb_w_q;
    cfg_inv_d = 1'b0;
    if (state_q[S_INIT]) begin
      arb_w_d = bus.arb_w_in;
      if (bus.th_low_in >= bus.th_high_in) begin
        cfg_inv_d = 1'b1;
      end else begin
        th_high_d = bus.th_high_in;
        th_low_d  = bus.th_low_in;
      end
    end
  end

  // event masks, paused flags and sticky overflow
  always_comb begin
    pmask_d    = pmask_q;
    cmask_d    = cmask_q;
    paused_d   = paused_q;
    err_full_d = err_full_q;
    if (state_q[S_ACTIVE]) begin
      pmask_d = pause_ev;
      cmask_d = cont_ev;
    end
    if (state_q[S_INIT])
      paused_d = '0;
    else if (state_q[S_PAUSE])
      paused_d = paused_q | pmask_q;
    else if (state_q[S_CONTINUE])
      paused_d = paused_q & ~cmask_q;
    if (state_q[S_ERROR] || err_any)
      err_full_d = err_full_q | err_ev;
    if (recover) begin
      paused_d   = '0;
      err_full_d = '0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      th_high_q  <= CNT_W'(TH_HIGH_DEF);
      th_low_q   <= CNT_W'(TH_LOW_DEF);
      arb_w_q    <= '0;
      paused_q   <= '0;
      pmask_q    <= '0;
      cmask_q    <= '0;
      err_full_q <= '0;
      cfg_inv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      th_high_q  <= th_high_d;
      th_low_q   <= th_low_d;
      arb_w_q    <= arb_w_d;
      paused_q   <= paused_d;
      pmask_q    <= pmask_d;
      cmask_q    <= cmask_d;
      err_full_q <= err_full_d;
      cfg_inv_q  <= cfg_inv_d;
    end
  end

  assign bus.th_high     = th_high_q;
  assign bus.th_low      = th_low_q;
  assign bus.arb_w       = arb_w_q;
  assign bus.state_o     = state_q;
  assign bus.idle        = state_q[S_IDLE];
  assign bus.pause_o     = state_q[S_PAUSE] ? pmask_q : '0;
  assign bus.continue_o  =
    state_q[S_CONTINUE] ? cmask_q : '0;
  assign bus.error_full  = err_full_q;
  assign bus.cfg_invalid = cfg_inv_q;

endmodule
